// File: rtl/req_gnt_pkg.sv
// Shared types and constants for the req/gnt responder slice.
package req_gnt_pkg;

  typedef enum logic [1:0] {
    RG_IDLE    = 2'd0,
    RG_GRANT   = 2'd1,
    RG_RECOVER = 2'd2
  } rg_state_e;

  localparam int unsigned REC_W         = 4;
  localparam int unsigned CNT_W_DEFAULT = 8;

endpackage

// File: rtl/req_gnt_responder_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a coincident increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_ip,
  input  logic         reset_ip,
  input  logic         clr_ip,
  input  logic         inc_ip,
  output logic [W-1:0] cnt_op
);

  always_ff @(posedge clk_ip or posedge reset_ip) begin
    if (reset_ip) begin
      cnt_op <= '0;
    end else if (clr_ip) begin
      cnt_op <= '0;
    end else if (inc_ip && (cnt_op != '1)) begin
      cnt_op <= cnt_op + W'(1);
    end
  end

endmodule

// File: rtl/req_gnt_responder.sv
// Grant-side responder: one-cycle gnt per accepted req, then a recovery window;
// requests seen while busy are dropped, flagged and counted.
module req_gnt_responder
  import req_gnt_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEFAULT,
  parameter int unsigned REC_CYCLES = 1
) (
  input  logic             clk_ip,
  input  logic             reset_ip,
  input  logic             en_ip,
  input  logic             req_ip,
  input  logic             clr_ip,
  output logic             gnt_op,
  output logic             busy_op,
  output logic             viol_op,
  output logic             err_op,
  output logic [CNT_W-1:0] gnt_cnt_op,
  output logic [CNT_W-1:0] viol_cnt_op
);

  localparam logic [REC_W-1:0] REC_LOAD = REC_W'(REC_CYCLES - 1);

  rg_state_e        state_q, state_d;
  logic [REC_W-1:0] rec_q, rec_d;
  logic             accept, viol;

  assign accept = (state_q == RG_IDLE) && req_ip && en_ip;
  assign viol   = (state_q != RG_IDLE) && req_ip;

  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    case (state_q)
      RG_IDLE: begin
        if (accept) state_d = RG_GRANT;
      end
      RG_GRANT: begin
        state_d = RG_RECOVER;
        rec_d   = REC_LOAD;
      end
      RG_RECOVER: begin
        if (rec_q == '0) state_d = RG_IDLE;
        else             rec_d   = rec_q - REC_W'(1);
      end
      default: state_d = RG_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with state_q
  // without any combinational path from req_ip.
  always_ff @(posedge clk_ip or posedge reset_ip) begin
    if (reset_ip) begin
      state_q <= RG_IDLE;
      rec_q   <= '0;
      gnt_op  <= 1'b0;
      busy_op <= 1'b0;
      viol_op <= 1'b0;
      err_op  <= 1'b0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      gnt_op  <= (state_d == RG_GRANT);
      busy_op <= (state_d != RG_IDLE);
      viol_op <= viol;
      if (clr_ip)    err_op <= 1'b0;
      else if (viol) err_op <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_gnt_cnt (
    .clk_ip   (clk_ip),
    .reset_ip (reset_ip),
    .clr_ip   (clr_ip),
    .inc_ip   (accept),
    .cnt_op   (gnt_cnt_op)
  );

  sat_counter #(.W(CNT_W)) u_viol_cnt (
    .clk_ip   (clk_ip),
    .reset_ip (reset_ip),
    .clr_ip   (clr_ip),
    .inc_ip   (viol),
    .cnt_op   (viol_cnt_op)
  );

endmodule

// File: tb/tb_req_gnt_responder.sv
// Directed bench for req_gnt_responder: default, CNT_W=2 and REC_CYCLES=3 instances share stimulus.
module tb_req_gnt_responder;

  logic clk_ip = 1'b0;
  logic reset_ip, en_ip, req_ip, clr_ip;

  always #5 clk_ip = ~clk_ip;

  logic       a_gnt, a_busy, a_viol, a_err;
  logic [7:0] a_gcnt, a_vcnt;
  logic       b_gnt, b_busy, b_viol, b_err;
  logic [1:0] b_gcnt, b_vcnt;
  logic       c_gnt, c_busy, c_viol, c_err;
  logic [7:0] c_gcnt, c_vcnt;

  req_gnt_responder #(.CNT_W(8), .REC_CYCLES(1)) dut_a (
    .clk_ip(clk_ip), .reset_ip(reset_ip), .en_ip(en_ip), .req_ip(req_ip), .clr_ip(clr_ip),
    .gnt_op(a_gnt), .busy_op(a_busy), .viol_op(a_viol), .err_op(a_err),
    .gnt_cnt_op(a_gcnt), .viol_cnt_op(a_vcnt));

  req_gnt_responder #(.CNT_W(2), .REC_CYCLES(1)) dut_b (
    .clk_ip(clk_ip), .reset_ip(reset_ip), .en_ip(en_ip), .req_ip(req_ip), .clr_ip(clr_ip),
    .gnt_op(b_gnt), .busy_op(b_busy), .viol_op(b_viol), .err_op(b_err),
    .gnt_cnt_op(b_gcnt), .viol_cnt_op(b_vcnt));

  req_gnt_responder #(.CNT_W(8), .REC_CYCLES(3)) dut_c (
    .clk_ip(clk_ip), .reset_ip(reset_ip), .en_ip(en_ip), .req_ip(req_ip), .clr_ip(clr_ip),
    .gnt_op(c_gnt), .busy_op(c_busy), .viol_op(c_viol), .err_op(c_err),
    .gnt_cnt_op(c_gcnt), .viol_cnt_op(c_vcnt));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_ip);
    #1;
  endtask

  task automatic do_reset();
    reset_ip = 1'b1;
    en_ip    = 1'b0;
    req_ip   = 1'b0;
    clr_ip   = 1'b0;
    step();
    step();
    reset_ip = 1'b0;
    step();
  endtask

  initial begin
    reset_ip = 1'b1;
    en_ip    = 1'b0;
    req_ip   = 1'b0;
    clr_ip   = 1'b0;
    step();
    chk("rst_gnt",   {31'd0, a_gnt},  32'd0);
    chk("rst_busy",  {31'd0, a_busy}, 32'd0);
    chk("rst_viol",  {31'd0, a_viol}, 32'd0);
    chk("rst_err",   {31'd0, a_err},  32'd0);
    chk("rst_gcnt",  {24'd0, a_gcnt}, 32'd0);
    chk("rst_vcnt",  {24'd0, a_vcnt}, 32'd0);

    // 1: single legal request
    do_reset();
    en_ip = 1'b1; req_ip = 1'b1; step(); req_ip = 1'b0;
    chk("t1_gnt_n1",  {31'd0, a_gnt},  32'd1);
    chk("t1_busy_n1", {31'd0, a_busy}, 32'd1);
    chk("t1_gcnt",    {24'd0, a_gcnt}, 32'd1);
    step();
    chk("t1_gnt_n2",  {31'd0, a_gnt},  32'd0);
    chk("t1_busy_n2", {31'd0, a_busy}, 32'd1);
    step();
    chk("t1_busy_n3", {31'd0, a_busy}, 32'd0);
    chk("t1_vcnt",    {24'd0, a_vcnt}, 32'd0);
    chk("t1_err",     {31'd0, a_err},  32'd0);

    // 2: request during RECOVER is a violation; next IDLE request is accepted
    do_reset();
    en_ip = 1'b1; req_ip = 1'b1; step(); req_ip = 1'b0;
    chk("t2_gnt",     {31'd0, a_gnt},  32'd1);
    step();
    chk("t2_rec_gnt", {31'd0, a_gnt},  32'd0);
    req_ip = 1'b1; step();
    chk("t2_viol",    {31'd0, a_viol}, 32'd1);
    chk("t2_vcnt",    {24'd0, a_vcnt}, 32'd1);
    chk("t2_err",     {31'd0, a_err},  32'd1);
    chk("t2_idle_g",  {31'd0, a_gnt},  32'd0);
    step(); req_ip = 1'b0;
    chk("t2_gnt2",    {31'd0, a_gnt},  32'd1);
    chk("t2_viol_lo", {31'd0, a_viol}, 32'd0);
    chk("t2_gcnt",    {24'd0, a_gcnt}, 32'd2);
    step(); step();

    // 3: disabled requests are ignored without violation
    do_reset();
    en_ip = 1'b0; req_ip = 1'b1; step(); req_ip = 1'b0;
    chk("t3_gnt_off",  {31'd0, a_gnt},  32'd0);
    chk("t3_viol_off", {31'd0, a_viol}, 32'd0);
    chk("t3_busy_off", {31'd0, a_busy}, 32'd0);
    chk("t3_gcnt_off", {24'd0, a_gcnt}, 32'd0);
    step(); step(); step();
    en_ip = 1'b1; req_ip = 1'b1; step(); req_ip = 1'b0;
    chk("t3_gnt_on",   {31'd0, a_gnt},  32'd1);
    step(); step();

    // 4: saturation at CNT_W=2, then clear; REC_CYCLES=3 instance sees violations
    do_reset();
    en_ip = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_ip = 1'b1; step(); req_ip = 1'b0; step(); step();
    end
    chk("t4_b_sat",   {30'd0, b_gcnt}, 32'd3);
    chk("t4_a_gcnt",  {24'd0, a_gcnt}, 32'd5);
    chk("t4_b_vcnt",  {30'd0, b_vcnt}, 32'd0);
    chk("t4_c_gcnt",  {24'd0, c_gcnt}, 32'd3);
    chk("t4_c_vcnt",  {24'd0, c_vcnt}, 32'd2);
    chk("t4_c_err",   {31'd0, c_err},  32'd1);
    clr_ip = 1'b1; step(); clr_ip = 1'b0;
    chk("t4_b_clr",   {30'd0, b_gcnt}, 32'd0);
    chk("t4_c_errc",  {31'd0, c_err},  32'd0);
    chk("t4_c_vclr",  {24'd0, c_vcnt}, 32'd0);
    step(); step(); step();

    // clr coincident with violation, then with an accepted request
    do_reset();
    en_ip = 1'b1; req_ip = 1'b1; step();
    clr_ip = 1'b1; step(); req_ip = 1'b0; clr_ip = 1'b0;
    chk("clrv_viol",  {31'd0, a_viol}, 32'd1);
    chk("clrv_vcnt",  {24'd0, a_vcnt}, 32'd0);
    chk("clrv_err",   {31'd0, a_err},  32'd0);
    step();
    req_ip = 1'b1; clr_ip = 1'b1; step(); req_ip = 1'b0; clr_ip = 1'b0;
    chk("clrg_gnt",   {31'd0, a_gnt},  32'd1);
    chk("clrg_gcnt",  {24'd0, a_gcnt}, 32'd0);
    step(); step();

    // 5: asynchronous reset mid-GRANT
    do_reset();
    en_ip = 1'b1; req_ip = 1'b1; step(); req_ip = 1'b0;
    chk("t5_pre_gnt", {31'd0, a_gnt},  32'd1);
    #2 reset_ip = 1'b1;
    #1;
    chk("t5_async_g", {31'd0, a_gnt},  32'd0);
    chk("t5_async_b", {31'd0, a_busy}, 32'd0);
    step(); reset_ip = 1'b0;
    step();
    chk("t5_post_g",  {31'd0, a_gnt},  32'd0);
    chk("t5_post_b",  {31'd0, a_busy}, 32'd0);
    req_ip = 1'b1; step(); req_ip = 1'b0;
    chk("t5_regnt",   {31'd0, a_gnt},  32'd1);
    step(); step();

    // 6: REC_CYCLES=3 occupancy and boundary requests
    do_reset();
    en_ip = 1'b1; req_ip = 1'b1; step(); req_ip = 1'b0;
    chk("t6_gnt_c6",  {31'd0, c_gnt},  32'd1);
    chk("t6_busy_c6", {31'd0, c_busy}, 32'd1);
    step();
    chk("t6_gnt_c7",  {31'd0, c_gnt},  32'd0);
    chk("t6_busy_c7", {31'd0, c_busy}, 32'd1);
    step();
    chk("t6_busy_c8", {31'd0, c_busy}, 32'd1);
    step();
    chk("t6_busy_c9", {31'd0, c_busy}, 32'd1);
    req_ip = 1'b1; step();
    chk("t6_viol_c10", {31'd0, c_viol}, 32'd1);
    chk("t6_busy_c10", {31'd0, c_busy}, 32'd0);
    chk("t6_gnt_c10",  {31'd0, c_gnt},  32'd0);
    step(); req_ip = 1'b0;
    chk("t6_gnt_c11",  {31'd0, c_gnt},  32'd1);
    chk("t6_viol_c11", {31'd0, c_viol}, 32'd0);
    chk("t6_vcnt",     {24'd0, c_vcnt}, 32'd1);
    chk("t6_gcnt",     {24'd0, c_gcnt}, 32'd2);
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
